// File: rtl/red_pkg.sv
// Shared types and helpers for the sequential lane-reduction unit.
package red_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StDone = 2'd2
    } red_state_t;

    // Number of lanes per operand.
    function automatic int unsigned lanes(int unsigned data_w, int unsigned lane_w);
        return data_w / lane_w;
    endfunction

    // Largest signed value representable in w bits.
    function automatic logic signed [63:0] sat_max(int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in w bits.
    function automatic logic signed [63:0] sat_min(int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/red_lane_add.sv
// One accumulation step: acc + sext(lane_a) + sext(lane_b), evaluated two bits wider
// than the accumulator so signed overflow is detectable.
// Macro RED_SAT_EN: clamp an overflowing result to the signed limits instead of wrapping.
module red_lane_add
    import red_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANE_W = 8
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [LANE_W-1:0] lane_a,
    input  logic [LANE_W-1:0] lane_b,
    output logic [DATA_W-1:0] next_acc,
    output logic              ovf
);

    localparam int unsigned WideW = DATA_W + 2;
    localparam logic signed [63:0] Max64 = sat_max(DATA_W);
    localparam logic signed [63:0] Min64 = sat_min(DATA_W);
    localparam logic signed [WideW-1:0] MaxW = Max64[WideW-1:0];
    localparam logic signed [WideW-1:0] MinW = Min64[WideW-1:0];

    logic signed [WideW-1:0] acc_w;
    logic signed [WideW-1:0] a_w;
    logic signed [WideW-1:0] b_w;
    logic signed [WideW-1:0] sum_w;

    // Wide signed add, range check and out-of-range handling.
    always_comb begin
        acc_w = {{2{acc[DATA_W-1]}}, acc};
        a_w   = {{(WideW - LANE_W){lane_a[LANE_W-1]}}, lane_a};
        b_w   = {{(WideW - LANE_W){lane_b[LANE_W-1]}}, lane_b};
        sum_w = acc_w + a_w + b_w;
        ovf   = (sum_w > MaxW) || (sum_w < MinW);
`ifdef RED_SAT_EN
        if (sum_w > MaxW) begin
            next_acc = MaxW[DATA_W-1:0];
        end else if (sum_w < MinW) begin
            next_acc = MinW[DATA_W-1:0];
        end else begin
            next_acc = sum_w[DATA_W-1:0];
        end
`else
        next_acc = sum_w[DATA_W-1:0];
`endif
    end

endmodule

// File: rtl/red_seq.sv
// Sequential signed lane reduction: sums all LANE_W lanes of two operands, one lane pair
// per cycle, with an optional accumulate mode that continues from the held previous sum.
// Macro RED_SAT_EN (in red_lane_add): saturate on overflow instead of wrapping.
module red_seq
    import red_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              acc_mode,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              ovf,
    output logic              busy
);

    localparam int unsigned L    = lanes(DATA_W, LANE_W);
    localparam int unsigned IdxW = (L > 1) ? $clog2(L) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(L - 1);

    red_state_t        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              ovf_q, ovf_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    logic [LANE_W-1:0] lane_a;
    logic [LANE_W-1:0] lane_b;
    logic [DATA_W-1:0] lane_next;
    logic              lane_ovf;

    // Select the current lane pair from the latched operands.
    always_comb begin
        lane_a = a_q[32'(idx_q) * LANE_W +: LANE_W];
        lane_b = b_q[32'(idx_q) * LANE_W +: LANE_W];
    end

    red_lane_add #(
        .DATA_W(DATA_W),
        .LANE_W(LANE_W)
    ) u_lane_add (
        .acc     (sum_q),
        .lane_a  (lane_a),
        .lane_b  (lane_b),
        .next_acc(lane_next),
        .ovf     (lane_ovf)
    );

    // FSM next state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (clr) begin
                    sum_d = '0;
                end
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    // A same-cycle clear wins over acc_mode.
                    if (!acc_mode || clr) begin
                        sum_d = '0;
                    end
                    state_d = StAcc;
                end
            end
            StAcc: begin
                sum_d = lane_next;
                ovf_d = ovf_q | lane_ovf;
                idx_d = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign sum  = sum_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != StIdle);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

endmodule
